// File: rtl/mux_seq_pkg.sv
// Shared types and default sizing for the mux readout sequencer.
package mux_seq_pkg;

  localparam int DEF_MUX_WIDTH     = 8;
  localparam int DEF_NUM_ROWS      = 8;
  localparam int DEF_SETTLE_CYCLES = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_PRIME,
    S_STREAM,
    S_DONE
  } state_t;

endpackage

// File: rtl/mux_readout_sequencer_settle_timer.sv
// Loadable down-counter that parks at zero and flags it.
module settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                    count <= '0;
    else if (load)                 count <= load_val;
    else if (dec && count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mux_readout_sequencer.sv
// Row/column scan sequencer driving a registered analog mux, with a
// valid/ready sample stream tagged by row and column.
module mux_readout_sequencer
  import mux_seq_pkg::*;
#(
  parameter int MUX_WIDTH     = DEF_MUX_WIDTH,
  parameter int NUM_ROWS      = DEF_NUM_ROWS,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  localparam int SW = $clog2(MUX_WIDTH),
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int CW = $clog2(SETTLE_CYCLES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic [SW-1:0] select,
  output logic [RW-1:0] row_sel,
  output logic          row_en,
  output logic          out_valid,
  output logic [SW-1:0] out_col,
  output logic [RW-1:0] out_row,
  output logic          out_last_col,
  output logic          out_last_frame,
  output logic          busy,
  output logic          done
);

  localparam logic [SW-1:0] COL_MAX   = SW'(MUX_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX   = RW'(NUM_ROWS - 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYCLES - 1);

  state_t        state, state_nx;
  logic [SW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx;
  logic          tmr_load, tmr_dec, tmr_zero;
  logic          last_col, last_row, fire;

  settle_timer #(.W(CW)) u_settle (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (SETTLE_LD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nx;
      col   <= col_nx;
      row   <= row_nx;
    end
  end

  assign last_col = (col == COL_MAX);
  assign last_row = (row == ROW_MAX);

  always_comb begin
    state_nx       = state;
    col_nx         = col;
    row_nx         = row;
    tmr_load       = 1'b0;
    tmr_dec        = 1'b0;
    select         = '0;
    row_en         = 1'b0;
    out_valid      = 1'b0;
    out_last_col   = 1'b0;
    out_last_frame = 1'b0;
    done           = 1'b0;
    fire           = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          state_nx = S_SETTLE;
          row_nx   = '0;
          col_nx   = '0;
          tmr_load = 1'b1;
        end
      end
      S_SETTLE: begin
        row_en = 1'b1;
        if (abort)         state_nx = S_IDLE;
        else if (tmr_zero) state_nx = S_PRIME;
        else               tmr_dec  = 1'b1;
      end
      S_PRIME: begin
        row_en = 1'b1;
        if (abort) state_nx = S_IDLE;
        else begin
          state_nx = S_STREAM;
          col_nx   = '0;
        end
      end
      S_STREAM: begin
        row_en         = 1'b1;
        out_valid      = 1'b1;
        out_last_col   = last_col;
        out_last_frame = last_col && last_row;
        fire           = out_ready;
        // The mux registers select, so advance it in the fire cycle; a stall
        // re-presents the current column and the mux recaptures it.
        select = (fire && !last_col) ? col + 1'b1 : col;
        if (abort) state_nx = S_IDLE;
        else if (fire) begin
          if (!last_col) col_nx = col + 1'b1;
          else if (!last_row) begin
            row_nx   = row + 1'b1;
            state_nx = S_SETTLE;
            tmr_load = 1'b1;
          end else state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy    = (state != S_IDLE);
  assign row_sel = row;
  assign out_col = col;
  assign out_row = row;

endmodule

// File: tb/tb_mux_readout_sequencer.sv
// Directed bench for mux_readout_sequencer with a registered-mux model.
module tb_mux_readout_sequencer;

  logic       clk = 1'b0;
  logic       reset, start, abort, out_ready;
  logic [2:0] select, out_col;
  logic       row_sel, out_row;
  logic       row_en, out_valid, out_last_col, out_last_frame, busy, done;

  logic [7:0] in_vec [8];
  logic [7:0] mux_q;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int final_fire = -1;

  mux_readout_sequencer #(.MUX_WIDTH(8), .NUM_ROWS(2), .SETTLE_CYCLES(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .out_ready      (out_ready),
    .select         (select),
    .row_sel        (row_sel),
    .row_en         (row_en),
    .out_valid      (out_valid),
    .out_col        (out_col),
    .out_row        (out_row),
    .out_last_col   (out_last_col),
    .out_last_frame (out_last_frame),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  // registered mux: one cycle from select to data
  always @(posedge clk) mux_q <= in_vec[select];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid;
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_select"}, {29'b0, select}, 0);
    chk({tag, "_row_sel"}, {31'b0, row_sel}, 0);
    chk({tag, "_row_en"}, {31'b0, row_en}, 0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 0);
    chk({tag, "_out_col"}, {29'b0, out_col}, 0);
    chk({tag, "_out_row"}, {31'b0, out_row}, 0);
    chk({tag, "_last_col"}, {31'b0, out_last_col}, 0);
    chk({tag, "_last_frame"}, {31'b0, out_last_frame}, 0);
    chk({tag, "_busy"}, {31'b0, busy}, 0);
    chk({tag, "_done"}, {31'b0, done}, 0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) in_vec[i] = 8'hA0 + 8'(i);
    reset = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    #3;
    chk_all_zero("reset");
    #9 reset = 1'b1;
    tick();

    // full frame, out_ready held high; start cycle is cycle 0
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
    chk("settle_busy", {31'b0, busy}, 1);
    chk("settle_row_en", {31'b0, row_en}, 1);
    chk("settle_valid", {31'b0, out_valid}, 0);
    wait_valid();
    chk("first_valid_cycle", cyc, 6);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 8; c++) begin
        wait_valid();
        chk("f_col", {29'b0, out_col}, c);
        chk("f_row", {31'b0, out_row}, r);
        chk("f_row_sel", {31'b0, row_sel}, r);
        chk("f_mux", {24'b0, mux_q}, {24'b0, in_vec[c]});
        chk("f_last_col", {31'b0, out_last_col}, (c == 7) ? 1 : 0);
        chk("f_last_frame", {31'b0, out_last_frame}, (c == 7 && r == 1) ? 1 : 0);
        chk("f_done", {31'b0, done}, 0);
        if (r == 1 && c == 7) final_fire = cyc;
        tick();
      end
    end
    chk("final_fire_cycle", final_fire, 26);
    chk("done_pulse", {31'b0, done}, 1);
    chk("done_row_en", {31'b0, row_en}, 0);
    chk("done_valid", {31'b0, out_valid}, 0);
    chk("done_busy", {31'b0, busy}, 1);
    tick();
    chk("idle_done", {31'b0, done}, 0);
    chk("idle_busy", {31'b0, busy}, 0);

    // backpressure at col 3, then abort mid-STREAM
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 40 && !(out_valid && out_col == 3'd3); n++) tick();
    chk("bp_reach_col3", {29'b0, out_col}, 3);
    out_ready = 1'b0;
    #1;
    chk("bp_select_hold", {29'b0, select}, 3);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_col", {29'b0, out_col}, 3);
      chk("bp_select", {29'b0, select}, 3);
      chk("bp_valid", {31'b0, out_valid}, 1);
      chk("bp_mux", {24'b0, mux_q}, {24'b0, in_vec[3]});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_select_adv", {29'b0, select}, 4);
    tick();
    chk("bp_resume_col", {29'b0, out_col}, 4);
    chk("bp_resume_mux", {24'b0, mux_q}, {24'b0, in_vec[4]});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abs_busy", {31'b0, busy}, 0);
    chk("abs_valid", {31'b0, out_valid}, 0);
    chk("abs_row_en", {31'b0, row_en}, 0);
    chk("abs_done", {31'b0, done}, 0);
    tick();
    chk("abs_done2", {31'b0, done}, 0);

    // abort in SETTLE
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abset_in_settle", {31'b0, row_en}, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abset_busy", {31'b0, busy}, 0);
    chk("abset_row_en", {31'b0, row_en}, 0);
    chk("abset_done", {31'b0, done}, 0);
    tick();
    chk("abset_done2", {31'b0, done}, 0);

    // restart scans from row 0; start during STREAM is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid();
    chk("rs_row", {31'b0, out_row}, 0);
    chk("rs_col", {29'b0, out_col}, 0);
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_col", {29'b0, out_col}, 3);
    chk("ign_row", {31'b0, out_row}, 0);
    chk("ign_valid", {31'b0, out_valid}, 1);

    // asynchronous reset mid-row, away from any clock edge
    #2 reset = 1'b0;
    #1;
    chk_all_zero("async_rst");
    #2 reset = 1'b1;
    tick();
    chk("post_rst_busy", {31'b0, busy}, 0);

    // start together with abort in IDLE stays idle
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", {31'b0, busy}, 0);
    chk("start_abort_row_en", {31'b0, row_en}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_readout_sequencer.md
MUX_READOUT_SEQUENCER -- requirements
Module: mux_readout_sequencer

Interface
REQ-001 Parameter MUX_WIDTH, default 8: number of mux inputs (columns) scanned per row; power of two, at least 2.
REQ-002 Parameter NUM_ROWS, default 8: rows per frame; at least 1.
REQ-003 Parameter SETTLE_CYCLES, default 4: row settle wait in cycles; at least 1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin one frame scan; sampled only in IDLE.
REQ-007 abort  in  1  terminate the scan immediately.
REQ-008 select  out  $clog2(MUX_WIDTH)  column select to the registered mux.
REQ-009 row_sel  out  $clog2(NUM_ROWS)  active row index.
REQ-010 row_en  out  1  row drive enable.
REQ-011 out_valid  out  1  mux output holds column out_col of row out_row.
REQ-012 out_ready  in  1  downstream accept; a transfer (fire) is out_valid and out_ready.
REQ-013 out_col / out_row  out  select / row_sel widths  tag of the current sample.
REQ-014 out_last_col / out_last_frame  out  1  current sample is the last column / the last sample of the frame.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on frame completion.

Function
REQ-017 States: IDLE, SETTLE, PRIME, STREAM, DONE.
REQ-018 IDLE: start=1 moves to SETTLE with row=0, settle count=SETTLE_CYCLES-1, row_en=1.
REQ-019 SETTLE: row_en=1, select=0; count decrements each cycle; at count 0 moves to PRIME.
REQ-020 PRIME: lasts exactly 1 cycle with select=0, covering the mux's one-cycle register latency; then moves to STREAM with col=0.
REQ-021 STREAM: out_valid=1, out_col=col, out_row=row.
REQ-022 STREAM select: col+1 when fire and col<MUX_WIDTH-1, otherwise col, so a stalled mux recaptures the same column; this is a combinational path from out_ready.
REQ-023 Fire with col<MUX_WIDTH-1: col increments and the state stays STREAM.
REQ-024 Fire with col=MUX_WIDTH-1 and row<NUM_ROWS-1: row increments, and the block moves to SETTLE with a reloaded count.
REQ-025 Fire with col=MUX_WIDTH-1 and row=NUM_ROWS-1: moves to DONE.
REQ-026 DONE: done=1 for one cycle, row_en=0, then IDLE.
REQ-027 out_last_col = (col==MUX_WIDTH-1) while in STREAM; out_last_frame = out_last_col and (row==NUM_ROWS-1).
REQ-028 out_valid, once asserted, stays high with stable tags until fire (no retraction except on abort).
REQ-029 abort=1 in any non-IDLE state: next state is IDLE; out_valid, row_en and busy drop next cycle; no done pulse; abort has priority over fire.
REQ-030 start is ignored outside IDLE; start and abort together in IDLE: stay in IDLE.
REQ-031 Outside STREAM: out_valid=0, out_last_*=0, select=0.
REQ-032 Outside SETTLE/PRIME/STREAM: row_en=0.
REQ-033 Counters never wrap; the settle counter is $clog2(SETTLE_CYCLES+1) bits wide.
REQ-034 Latency with out_ready held high: start in cycle 0 gives the first out_valid in cycle SETTLE_CYCLES+2.
REQ-035 Frame length with out_ready held high: NUM_ROWS*(SETTLE_CYCLES+1+MUX_WIDTH) cycles from the first SETTLE cycle to the final fire.

Reset
REQ-036 reset low, asynchronously: state=IDLE, col=0, row=0, count=0.
REQ-037 During reset all outputs are 0: select, row_sel, row_en, out_valid, out_col, out_row, out_last_col, out_last_frame, busy, done.
REQ-038 Reset deassertion takes effect on the first clk edge; reset mid-frame discards the frame with no done pulse.

Structure
REQ-039 Package mux_seq_pkg holds the state enum typedef and the default parameter constants.
REQ-040 One sub-module, settle_timer: a loadable down-counter with a zero flag, instantiated once.

Verification
REQ-041 MUX_WIDTH=8, NUM_ROWS=2, SETTLE_CYCLES=4, out_ready=1, start in cycle 0 -> out_valid first in cycle 6; tags (0,0)..(0,7), then (1,0)..(1,7); done in the cycle after the final fire; 26 cycles from the first SETTLE cycle to the final fire.
REQ-042 Backpressure: out_ready=0 for 3 cycles at col 3 -> out_col stays 3 and select stays 3 for those cycles; the value at col 3 equals in[3]; scan then resumes at col 4.
REQ-043 abort asserted in SETTLE and again mid-STREAM (separate runs) -> IDLE next cycle; busy=0, out_valid=0, no done pulse; a following start rescans from row 0.
REQ-044 start pulsed during STREAM -> no effect on col, row or state.
REQ-045 reset driven low asynchronously mid-row (no clock edge) -> all outputs read 0 immediately.
REQ-046 last flags: out_last_col=1 only at col 7; out_last_frame=1 only at (row 1, col 7).
